mtr_sequencer: RTL and testbench

MTR_SEQUENCER -- requirements
Module: mtr_sequencer

---
 rtl/mtr_pkg.sv | 26 ++
 rtl/mag_slew.sv | 28 ++
 rtl/mtr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mtr_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and default tuning for the assist-motor sequencer.
package mtr_pkg;

  localparam int unsigned MagW  = 12;
  localparam int unsigned HallW = 3;

  localparam int unsigned     DefStep     = 16;
  localparam logic [MagW-1:0] DefStallMag = 12'h100;
  localparam int unsigned     DefStallPer = 1024;
  localparam int unsigned     DefBrkMin   = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRamp  = 3'd1,
    StRun   = 3'd2,
    StDecel = 3'd3,
    StBrake = 3'd4,
    StFault = 3'd5
  } mtr_state_e;

  // All-low or all-high hall vectors cannot occur on a healthy motor.
  function automatic logic hall_illegal(input logic [HallW-1:0] h);
    return (h == '0) || (h == '1);
  endfunction

endpackage

// File: rtl/mag_slew.sv
// Moves a magnitude toward a target by at most one step; never overshoots or wraps.
module mag_slew
  import mtr_pkg::*;
(
  input  logic [MagW-1:0] cur,
  input  logic [MagW-1:0] tgt,
  input  logic [MagW-1:0] step,
  input  logic            en_step,
  output logic [MagW-1:0] next
);

  logic [MagW-1:0] diff;

  always_comb begin
    next = cur;
    diff = '0;
    if (en_step) begin
      if (tgt > cur) begin
        diff = tgt - cur;
        next = (diff > step) ? cur + step : tgt;
      end else if (tgt < cur) begin
        diff = cur - tgt;
        next = (diff > step) ? cur - step : tgt;
      end
    end
  end

endmodule

// File: rtl/mtr_sequencer.sv
// Assist-motor sequencer: slew-limited ramp/decel, braking hold, stall and
// illegal-hall fault detection. All outputs are registered.
module mtr_sequencer
  import mtr_pkg::*;
#(
  parameter int unsigned     STEP      = DefStep,
  parameter logic [MagW-1:0] STALL_MAG = DefStallMag,
  parameter int unsigned     STALL_PER = DefStallPer,
  parameter int unsigned     BRK_MIN   = DefBrkMin
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             brake_req,
  input  logic [MagW-1:0]  target_mag,
  input  logic [HallW-1:0] hall_state,
  input  logic             PWM_synch,
  input  logic             clr_fault,
  output logic [MagW-1:0]  drv_mag,
  output logic             brake_n,
  output logic             fault,
  output logic [2:0]       state
);

  localparam int unsigned StallW = $clog2(STALL_PER + 1);
  localparam int unsigned BrkW   = $clog2(BRK_MIN + 1);

  localparam logic [StallW-1:0] StallLast = StallW'(STALL_PER - 1);
  localparam logic [BrkW-1:0]   BrkLim    = BrkW'(BRK_MIN);

  mtr_state_e        state_q, state_d;
  logic [MagW-1:0]   drv_mag_q, drv_mag_d;
  logic              brake_n_q, fault_q;
  logic [HallW-1:0]  hall_prev_q, hall_prev_d;
  logic              bad_hall_q, bad_hall_d;
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic [BrkW-1:0]   brk_cnt_q, brk_cnt_d;

  logic            run_like;
  logic            stall_armed;
  logic            hall_same;
  logic            stall_hit;
  logic            hall_hit;
  logic [BrkW-1:0] brk_inc;
  logic [MagW-1:0] slew_tgt;
  logic            slew_en;
  logic [MagW-1:0] slew_mag;

  assign run_like    = (state_q == StRamp) || (state_q == StRun);
  assign stall_armed = (state_q == StRun) && (drv_mag_q >= STALL_MAG);
  assign hall_same   = (hall_state == hall_prev_q);
  assign stall_hit   = stall_armed && PWM_synch && hall_same && (stall_cnt_q >= StallLast);
  assign hall_hit    = run_like && PWM_synch && hall_illegal(hall_state) && bad_hall_q;
  assign brk_inc     = (brk_cnt_q >= BrkLim) ? BrkLim : brk_cnt_q + BrkW'(PWM_synch);

  // Dropping en in RAMP/RUN starts the decel slew on the same PWM tick.
  assign slew_tgt = (en && run_like) ? target_mag : '0;
  assign slew_en  = PWM_synch && (run_like || (state_q == StDecel));

  mag_slew u_mag_slew (
    .cur     (drv_mag_q),
    .tgt     (slew_tgt),
    .step    (MagW'(STEP)),
    .en_step (slew_en),
    .next    (slew_mag)
  );

  always_comb begin
    state_d   = state_q;
    drv_mag_d = drv_mag_q;
    if (state_q == StFault) begin
      drv_mag_d = '0;
      if (clr_fault && !en) state_d = StIdle;
    end else if (stall_hit || hall_hit) begin
      state_d   = StFault;
      drv_mag_d = '0;
    end else if (brake_req) begin
      state_d   = StBrake;
      drv_mag_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          drv_mag_d = '0;
          if (en) state_d = StRamp;
        end
        StRamp, StRun: begin
          drv_mag_d = slew_mag;
          if (!en) begin
            state_d = StDecel;
          end else if ((state_q == StRamp) && (drv_mag_q == target_mag)) begin
            state_d = StRun;
          end
        end
        StDecel: begin
          drv_mag_d = slew_mag;
          if (en) begin
            state_d = StRamp;
          end else if (drv_mag_q == '0) begin
            state_d = StIdle;
          end
        end
        StBrake: begin
          drv_mag_d = '0;
          if (brk_inc >= BrkLim) state_d = StIdle;
        end
        default: begin
          state_d   = StIdle;
          drv_mag_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    hall_prev_d = PWM_synch ? hall_state : hall_prev_q;

    bad_hall_d = 1'b0;
    if (run_like) bad_hall_d = PWM_synch ? hall_illegal(hall_state) : bad_hall_q;

    stall_cnt_d = '0;
    if (stall_armed) begin
      if (PWM_synch) begin
        stall_cnt_d = hall_same ? stall_cnt_q + 1'b1 : '0;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end

    // Counting restarts on every BRAKE entry because it only runs while in BRAKE.
    brk_cnt_d = (state_q == StBrake) ? brk_inc : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      drv_mag_q   <= '0;
      brake_n_q   <= 1'b1;
      fault_q     <= 1'b0;
      hall_prev_q <= '0;
      bad_hall_q  <= 1'b0;
      stall_cnt_q <= '0;
      brk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      drv_mag_q   <= drv_mag_d;
      brake_n_q   <= (state_d != StBrake);
      fault_q     <= (state_d == StFault);
      hall_prev_q <= hall_prev_d;
      bad_hall_q  <= bad_hall_d;
      stall_cnt_q <= stall_cnt_d;
      brk_cnt_q   <= brk_cnt_d;
    end
  end

  assign drv_mag = drv_mag_q;
  assign brake_n = brake_n_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mtr_sequencer.sv
// Bench for mtr_sequencer: directed scenarios plus randomized run against a reference model.
`timescale 1ns/1ps
module tb_mtr_sequencer;
  import mtr_pkg::*;

  localparam int TStep     = 16;
  localparam int TStallMag = 'h100;
  localparam int TStallPer = 1024;
  localparam int TBrkMin   = 8;

  logic        clk = 1'b0;
  logic        rst, en, brake_req, PWM_synch, clr_fault;
  logic [11:0] target_mag;
  logic [2:0]  hall_state;
  logic [11:0] drv_mag;
  logic        brake_n, fault;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  mtr_state_e m_state = StIdle;
  int         m_mag   = 0;
  int         m_brk   = 0;
  int         m_stall = 0;
  logic [2:0] m_prev  = 3'b000;
  bit         m_bad   = 1'b0;

  always #10 clk = ~clk;

  mtr_sequencer #(
    .STEP      (16),
    .STALL_MAG (12'h100),
    .STALL_PER (1024),
    .BRK_MIN   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .brake_req  (brake_req),
    .target_mag (target_mag),
    .hall_state (hall_state),
    .PWM_synch  (PWM_synch),
    .clr_fault  (clr_fault),
    .drv_mag    (drv_mag),
    .brake_n    (brake_n),
    .fault      (fault),
    .state      (state)
  );

  function automatic int toward(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > TStep) d = TStep;
    else if (d < -TStep) d = -TStep;
    return cur + d;
  endfunction

  task automatic model_step();
    bit pwm, ill, runlike, armed, same, stall_f, hall_f;
    int brk_inc, nmag;
    mtr_state_e ns;
    if (rst) begin
      m_state = StIdle; m_mag = 0; m_brk = 0; m_stall = 0; m_prev = 3'b000; m_bad = 1'b0;
      return;
    end
    pwm     = PWM_synch;
    ill     = (hall_state == 3'b000) || (hall_state == 3'b111);
    runlike = (m_state == StRamp) || (m_state == StRun);
    armed   = (m_state == StRun) && (m_mag >= TStallMag);
    same    = (hall_state == m_prev);
    stall_f = armed && pwm && same && (m_stall + 1 >= TStallPer);
    hall_f  = runlike && pwm && ill && m_bad;
    brk_inc = m_brk + int'(pwm);
    if (brk_inc > TBrkMin) brk_inc = TBrkMin;
    ns   = m_state;
    nmag = m_mag;
    if (m_state == StFault) begin
      nmag = 0;
      if (clr_fault && !en) ns = StIdle;
    end else if (stall_f || hall_f) begin
      ns = StFault; nmag = 0;
    end else if (brake_req) begin
      ns = StBrake; nmag = 0;
    end else begin
      case (m_state)
        StIdle: if (en) ns = StRamp;
        StRamp, StRun: begin
          if (!en) begin
            ns = StDecel;
            if (pwm) nmag = toward(m_mag, 0);
          end else begin
            if (pwm) nmag = toward(m_mag, int'(target_mag));
            if (m_state == StRamp && m_mag == int'(target_mag)) ns = StRun;
          end
        end
        StDecel: begin
          if (pwm) nmag = toward(m_mag, 0);
          if (en) ns = StRamp;
          else if (m_mag == 0) ns = StIdle;
        end
        StBrake: if (brk_inc >= TBrkMin) ns = StIdle;
        default: ;
      endcase
    end
    if (!armed) m_stall = 0;
    else if (pwm) m_stall = same ? m_stall + 1 : 0;
    if (!runlike) m_bad = 1'b0;
    else if (pwm) m_bad = ill;
    m_brk = (m_state == StBrake) ? brk_inc : 0;
    if (pwm) m_prev = hall_state;
    m_state = ns;
    m_mag   = nmag;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pwm_pulse();
    PWM_synch = 1'b1;
    tick();
    PWM_synch = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (state !== StIdle || drv_mag !== 12'h000 || brake_n !== 1'b1 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d mag=%h brake_n=%b fault=%b, expected 0/000/1/0",
               state, drv_mag, brake_n, fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    en = 1'b1; target_mag = 12'h080; hall_state = 3'b001;
    tick();
    n_checks++;
    if (state !== StRamp) begin
      n_fail++; $display("FAIL ramp_entry: state=%0d expected %0d", state, StRamp);
    end
    for (int k = 1; k <= 8; k++) begin
      pwm_pulse();
      n_checks++;
      if (drv_mag !== 12'(k * 16)) begin
        n_fail++; $display("FAIL ramp_step%0d: drv_mag=%h expected %h", k, drv_mag, 12'(k * 16));
      end
      repeat (15) tick();
      n_checks++;
      if (drv_mag !== 12'(k * 16)) begin
        n_fail++; $display("FAIL ramp_hold%0d: drv_mag=%h expected %h", k, drv_mag, 12'(k * 16));
      end
    end
    n_checks++;
    if (state !== StRun) begin
      n_fail++; $display("FAIL ramp_run: state=%0d expected %0d", state, StRun);
    end
  endtask

  task automatic test_retarget_decel();
    int exp_mag;
    target_mag = 12'h078;
    pwm_pulse();
    n_checks++;
    if (drv_mag !== 12'h078) begin
      n_fail++; $display("FAIL retarget: drv_mag=%h expected 078", drv_mag);
    end
    repeat (15) tick();
    n_checks++;
    if (state !== StRun) begin
      n_fail++; $display("FAIL retarget_run: state=%0d expected %0d", state, StRun);
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (state !== StDecel) begin
      n_fail++; $display("FAIL decel_entry: state=%0d expected %0d", state, StDecel);
    end
    for (int k = 1; k <= 8; k++) begin
      pwm_pulse();
      exp_mag = (k == 8) ? 0 : 'h78 - 16 * k;
      n_checks++;
      if (drv_mag !== 12'(exp_mag)) begin
        n_fail++; $display("FAIL decel_step%0d: drv_mag=%h expected %h", k, drv_mag, 12'(exp_mag));
      end
      repeat (15) tick();
    end
    n_checks++;
    if (state !== StIdle) begin
      n_fail++; $display("FAIL decel_idle: state=%0d expected %0d", state, StIdle);
    end
  endtask

  task automatic test_brake();
    en = 1'b1; target_mag = 12'h080;
    tick();
    repeat (8) begin
      pwm_pulse();
      repeat (15) tick();
    end
    n_checks++;
    if (state !== StRun || drv_mag !== 12'h080) begin
      n_fail++; $display("FAIL brake_pre: state=%0d mag=%h expected %0d/080", state, drv_mag, StRun);
    end
    brake_req = 1'b1; en = 1'b0;
    tick();
    n_checks++;
    if (brake_n !== 1'b0 || drv_mag !== 12'h000 || state !== StBrake) begin
      n_fail++;
      $display("FAIL brake_entry: brake_n=%b mag=%h state=%0d expected 0/000/%0d",
               brake_n, drv_mag, state, StBrake);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) brake_req = 1'b0;
      pwm_pulse();
      if (k == 7) begin
        n_checks++;
        if (state !== StBrake || brake_n !== 1'b0) begin
          n_fail++; $display("FAIL brake_hold7: state=%0d brake_n=%b expected %0d/0",
                             state, brake_n, StBrake);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (state !== StIdle || brake_n !== 1'b1) begin
          n_fail++; $display("FAIL brake_exit8: state=%0d brake_n=%b expected %0d/1",
                             state, brake_n, StIdle);
        end
      end
      repeat (15) tick();
    end
  endtask

  task automatic test_illegal_hall();
    en = 1'b1; target_mag = 12'h080; hall_state = 3'b001;
    tick();
    pwm_pulse();
    hall_state = 3'b111;
    pwm_pulse();
    n_checks++;
    if (fault !== 1'b0 || drv_mag !== 12'h020) begin
      n_fail++; $display("FAIL hall_first: fault=%b mag=%h expected 0/020", fault, drv_mag);
    end
    pwm_pulse();
    n_checks++;
    if (fault !== 1'b1 || state !== StFault || drv_mag !== 12'h000 || brake_n !== 1'b1) begin
      n_fail++;
      $display("FAIL hall_fault: fault=%b state=%0d mag=%h brake_n=%b expected 1/%0d/000/1",
               fault, state, drv_mag, brake_n, StFault);
    end
    hall_state = 3'b001; clr_fault = 1'b1; en = 1'b1;
    tick();
    n_checks++;
    if (state !== StFault || fault !== 1'b1) begin
      n_fail++; $display("FAIL clr_with_en: state=%0d fault=%b expected %0d/1", state, fault, StFault);
    end
    en = 1'b0;
    tick();
    clr_fault = 1'b0;
    n_checks++;
    if (state !== StIdle || fault !== 1'b0) begin
      n_fail++; $display("FAIL clr_no_en: state=%0d fault=%b expected %0d/0", state, fault, StIdle);
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; target_mag = 12'h080;
    tick();
    repeat (4) pwm_pulse();
    n_checks++;
    if (drv_mag !== 12'h040 || state !== StRamp) begin
      n_fail++; $display("FAIL mid_ramp: mag=%h state=%0d expected 040/%0d", drv_mag, state, StRamp);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    n_checks++;
    if (drv_mag !== 12'h000 || state !== StIdle || brake_n !== 1'b1 || fault !== 1'b0) begin
      n_fail++; $display("FAIL rst_ramp: mag=%h state=%0d brake_n=%b expected 000/%0d/1",
                         drv_mag, state, brake_n, StIdle);
    end
    brake_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (state !== StIdle || brake_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_brake: state=%0d brake_n=%b expected %0d/1", state, brake_n, StIdle);
    end
    brake_req = 1'b0;
  endtask

  task automatic ramp_to_200();
    en = 1'b1; target_mag = 12'h200; hall_state = 3'b001;
    tick();
    repeat (32) begin
      pwm_pulse();
      repeat (3) tick();
    end
  endtask

  task automatic test_stall();
    ramp_to_200();
    n_checks++;
    if (state !== StRun || drv_mag !== 12'h200) begin
      n_fail++; $display("FAIL stall_pre: state=%0d mag=%h expected %0d/200", state, drv_mag, StRun);
    end
    for (int k = 1; k <= TStallPer; k++) begin
      pwm_pulse();
      if (k == TStallPer - 1) begin
        n_checks++;
        if (fault !== 1'b0 || state !== StRun) begin
          n_fail++; $display("FAIL stall_early: fault=%b state=%0d expected 0/%0d", fault, state, StRun);
        end
      end
      if (k == TStallPer) begin
        n_checks++;
        if (fault !== 1'b1 || drv_mag !== 12'h000 || brake_n !== 1'b1) begin
          n_fail++; $display("FAIL stall_fault: fault=%b mag=%h brake_n=%b expected 1/000/1",
                             fault, drv_mag, brake_n);
        end
      end
      repeat (3) tick();
    end
    clr_fault = 1'b1; en = 1'b0;
    tick();
    clr_fault = 1'b0;
    ramp_to_200();
    for (int k = 1; k <= 1100; k++) begin
      if (k == 1000) hall_state = 3'b011;
      pwm_pulse();
      if (k == TStallPer) begin
        n_checks++;
        if (fault !== 1'b0) begin
          n_fail++; $display("FAIL stall_toggle1024: fault=%b expected 0", fault);
        end
      end
      repeat (3) tick();
    end
    n_checks++;
    if (fault !== 1'b0 || state !== StRun) begin
      n_fail++; $display("FAIL stall_toggle_end: fault=%b state=%0d expected 0/%0d", fault, state, StRun);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; hall_state = 3'b001;
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 79) == 0) brake_req = ~brake_req;
      if ($urandom_range(0, 39) == 0) target_mag = 12'($urandom);
      if ($urandom_range(0, 9) == 0) hall_state = 3'($urandom);
      PWM_synch = ($urandom_range(0, 5) == 0);
      clr_fault = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 799) == 0);
      tick();
      n_checks++;
      if (state !== m_state || drv_mag !== 12'(m_mag) || brake_n !== (m_state != StBrake) ||
          fault !== (m_state == StFault)) begin
        n_fail++;
        $display("FAIL random_cyc%0d: state=%0d mag=%h brake_n=%b fault=%b expected %0d/%h/%b/%b",
                 i, state, drv_mag, brake_n, fault, m_state, 12'(m_mag),
                 (m_state != StBrake), (m_state == StFault));
      end
    end
    PWM_synch = 1'b0; clr_fault = 1'b0; rst = 1'b0; brake_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; brake_req = 1'b0; PWM_synch = 1'b0; clr_fault = 1'b0;
    target_mag = 12'h000; hall_state = 3'b001;
    test_reset();
    test_ramp();
    test_retarget_decel();
    test_brake();
    test_illegal_hall();
    test_reset_mid();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
